// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
package riscv_ctrl_pkg;

    // FSM states; encodings 12..15 are unused and recover to StFetch.
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10,
        StTrap     = 4'd11
    } state_t;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Immediate format
    localparam logic [1:0] IMMSRC_I = 2'b00;
    localparam logic [1:0] IMMSRC_S = 2'b01;
    localparam logic [1:0] IMMSRC_B = 2'b10;
    localparam logic [1:0] IMMSRC_J = 2'b11;

    // Register-file write-back source
    localparam logic [1:0] RESSRC_ALUOUT = 2'b00;
    localparam logic [1:0] RESSRC_RDATA  = 2'b01;
    localparam logic [1:0] RESSRC_ALURES = 2'b10;

    // ALU operand A source
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B source
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/riscv_imm_src_dec.sv
// Opcode to immediate-format decoder; purely combinational, state independent.
module riscv_imm_src_dec
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned IMMSRC_W = 2
) (
    input  logic [6:0]          op,
    output logic [IMMSRC_W-1:0] imm_src
);

    // Select the immediate layout for the opcode currently in the IR
    always_comb begin
        imm_src = IMMSRC_W'(IMMSRC_I);
        unique case (op)
            OP_SW:     imm_src = IMMSRC_W'(IMMSRC_S);
            OP_BRANCH: imm_src = IMMSRC_W'(IMMSRC_B);
            OP_JAL:    imm_src = IMMSRC_W'(IMMSRC_J);
            default:   imm_src = IMMSRC_W'(IMMSRC_I);
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RISC-V control FSM: sequences lw/sw/R/I/branch/jal and drives datapath controls.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter bit          HANDSHAKE = 1'b1,
    parameter bit          BNE_EN    = 1'b1,
    parameter int unsigned IMMSRC_W  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                adr_src,
    output logic                ir_write,
    output logic                mem_write,
    output logic                reg_write,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          result_src,
    output logic [IMMSRC_W-1:0] imm_src,
    output logic                instr_done,
    output logic                illegal_instr
);

    state_t state;
    logic   rdy;
    logic   taken;
    logic   pc_write_raw;
    logic   ir_write_raw;
    logic   mem_write_raw;
    logic   reg_write_raw;
    logic   instr_done_raw;
    logic   unused_funct3;

    assign rdy           = HANDSHAKE ? mem_ready : 1'b1;
    assign taken         = BNE_EN ? (zero ^ funct3[0]) : zero;
    assign unused_funct3 = ^funct3[2:1];

    // State register with next-state selection; reset aborts any instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StFetch;
        end else begin
            case (state)
                StFetch:    if (rdy) state <= StDecode;
                StDecode: begin
                    case (op)
                        OP_LW, OP_SW: state <= StMemAdr;
                        OP_R:         state <= StExecR;
                        OP_I:         state <= StExecI;
                        OP_BRANCH:    state <= StBeq;
                        OP_JAL:       state <= StJal;
                        default:      state <= StTrap;
                    endcase
                end
                StMemAdr:   state <= (op == OP_SW) ? StMemWrite : StMemRead;
                StMemRead:  if (rdy) state <= StMemWb;
                StMemWb:    state <= StFetch;
                StMemWrite: if (rdy) state <= StFetch;
                StExecR:    state <= StAluWb;
                StExecI:    state <= StAluWb;
                StAluWb:    state <= StFetch;
                StBeq:      state <= StFetch;
                StJal:      state <= StAluWb;
                StTrap:     state <= StTrap;
                default:    state <= StFetch;
            endcase
        end
    end

    // Moore output decode; strobes additionally depend on rdy and the branch outcome
    always_comb begin
        pc_write_raw   = 1'b0;
        ir_write_raw   = 1'b0;
        mem_write_raw  = 1'b0;
        reg_write_raw  = 1'b0;
        instr_done_raw = 1'b0;
        adr_src        = 1'b0;
        alu_src_a      = SRCA_PC;
        alu_src_b      = SRCB_RS2;
        alu_op         = ALUOP_ADD;
        result_src     = RESSRC_ALUOUT;
        illegal_instr  = 1'b0;
        case (state)
            StDecode: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            StMemAdr: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            StMemRead: begin
                adr_src = 1'b1;
            end
            StMemWb: begin
                result_src     = RESSRC_RDATA;
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            StMemWrite: begin
                // strobe held through wait cycles; completion only once memory accepts
                adr_src        = 1'b1;
                mem_write_raw  = 1'b1;
                instr_done_raw = rdy;
            end
            StExecR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            StExecI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            StAluWb: begin
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            StBeq: begin
                alu_src_a      = SRCA_RS1;
                alu_src_b      = SRCB_RS2;
                alu_op         = ALUOP_SUB;
                pc_write_raw   = taken;
                instr_done_raw = 1'b1;
            end
            StJal: begin
                // ALUOut already holds the target from DECODE; ALU forms OldPC+4 for rd
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                pc_write_raw = 1'b1;
            end
            StTrap: begin
                illegal_instr = 1'b1;
            end
            default: begin
                // StFetch and unused encodings present fetch controls
                alu_src_b    = SRCB_FOUR;
                result_src   = RESSRC_ALURES;
                pc_write_raw = rdy;
                ir_write_raw = rdy;
            end
        endcase
    end

    // Strobes are forced low for the whole reset interval, not just after the first edge
    assign pc_write   = pc_write_raw   & ~reset;
    assign ir_write   = ir_write_raw   & ~reset;
    assign mem_write  = mem_write_raw  & ~reset;
    assign reg_write  = reg_write_raw  & ~reset;
    assign instr_done = instr_done_raw & ~reset;

    riscv_imm_src_dec #(
        .IMMSRC_W (IMMSRC_W)
    ) u_imm_src_dec (
        .op      (op),
        .imm_src (imm_src)
    );

endmodule
